// File: rtl/cheb_pkg.sv
// cheb_pkg: shared FSM state encoding and ceil-log2 helper for the Chebyshev sum sequencer.
package cheb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WAIT1  = 3'd2,
        WAIT2  = 3'd3,
        FINISH = 3'd4
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/cheb_sum_ctrl.sv
// cheb_sum_ctrl: sequences DEGREE+1 signed terms through a shared registered adder
// and publishes the accumulated sum with a one-cycle done pulse.
module cheb_sum_ctrl
    import cheb_pkg::*;
#(
    parameter  int DEGREE   = 3,
    parameter  int WL_TERM  = 16,
    localparam int WIDENING = (clog2(DEGREE + 1) < 1) ? 1 : clog2(DEGREE + 1),
    localparam int WL_ACC   = WL_TERM + WIDENING
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              term_valid,
    input  logic [WL_TERM-1:0] term_data,
    output logic              term_ready,
    output logic [WL_ACC-1:0] add_a,
    output logic [WL_ACC-1:0] add_b,
    input  logic [WL_ACC-1:0] add_sum,
    output logic              busy,
    output logic              done,
    output logic [WL_ACC-1:0] sum
);

    localparam int CW = clog2(DEGREE + 2);

    state_t            state, state_next;
    logic [WL_ACC-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              hs;

    always_comb begin
        state_next = state;
        term_ready = (state == ACCEPT);
        hs         = term_valid && term_ready;
        case (state)
            IDLE:    state_next = start ? ACCEPT : IDLE;
            ACCEPT:  state_next = hs ? WAIT1 : ACCEPT;
            WAIT1:   state_next = WAIT2;
            WAIT2:   state_next = (cnt == CW'(DEGREE + 1)) ? FINISH : ACCEPT;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done is registered together with sum so the result is stable while done is high
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            add_a <= '0;
            add_b <= '0;
            sum   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FINISH);
            case (state)
                IDLE: if (start) begin
                    acc  <= '0;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
                ACCEPT: if (hs) begin
                    add_a <= acc;
                    add_b <= {{WIDENING{term_data[WL_TERM-1]}}, term_data};
                    cnt   <= cnt + CW'(1);
                end
                WAIT2:  acc <= add_sum;
                FINISH: begin
                    sum  <= acc;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cheb_sum_ctrl.sv
// tb_cheb_sum_ctrl: directed bench for cheb_sum_ctrl with a behavioural model of the
// shared adder's sum register beside each instance.
module tb_cheb_sum_ctrl;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, term_valid = 1'b0;
    logic [15:0] term_data = '0;
    logic        term_ready, busy, done;
    logic [17:0] add_a, add_b, add_sum, sum;

    logic        z_start = 1'b0, z_valid = 1'b0;
    logic [15:0] z_data = '0;
    logic        z_ready, z_busy, z_done;
    logic [16:0] z_a, z_b, z_s, z_sum;

    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    // add_a/add_b are the adder's operand stage; this is its sum stage (resetn = ~reset)
    always_ff @(posedge clock) begin
        add_sum <= reset ? '0 : add_a + add_b;
        z_s     <= reset ? '0 : z_a + z_b;
    end

    cheb_sum_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .term_valid(term_valid),
        .term_data(term_data), .term_ready(term_ready), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .busy(busy), .done(done), .sum(sum)
    );

    cheb_sum_ctrl #(.DEGREE(0), .WL_TERM(16)) dut0 (
        .clock(clock), .reset(reset), .start(z_start), .term_valid(z_valid),
        .term_data(z_data), .term_ready(z_ready), .add_a(z_a), .add_b(z_b),
        .add_sum(z_s), .busy(z_busy), .done(z_done), .sum(z_sum)
    );

    task automatic run_eval(input int t0, t1, t2, t3, input int stall_len, input int start_at,
                            input int tail, output int done_cyc, output logic [17:0] got,
                            output int ndone, output bit busy_ok, output bit sum_early);
        int terms[4];
        int idx = 0, cyc = 0, stalled = 0, limit = 200;
        bit hs, stall;
        logic [17:0] prev;
        terms = '{t0, t1, t2, t3};
        done_cyc = -1; ndone = 0; busy_ok = 1; sum_early = 0; got = 'x;
        prev = sum;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (cyc < limit) begin
            stall = (idx == 2) && (stalled < stall_len) && term_ready;
            if (stall) stalled++;
            term_valid = (idx < 4) && !stall;
            term_data  = (idx < 4) ? 16'(terms[idx]) : '0;
            start      = (cyc == start_at);
            @(negedge clock);
            hs = term_valid && term_ready;
            @(posedge clock); #1;
            cyc++;
            if (hs) idx++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; got = sum; limit = cyc + tail;
                    if (busy) busy_ok = 0;
                end
            end else if (done_cyc < 0) begin
                if (!busy) busy_ok = 0;
                if (sum !== prev) sum_early = 1;
            end
        end
        term_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sum !== 18'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", sum); end
        checks++; if (term_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", term_ready); end
        checks++; if (add_a !== 18'd0 || add_b !== 18'd0) begin errors++; $display("FAIL reset_operands got %0h/%0h want 0/0", add_a, add_b); end
        reset = 1'b0; start = 1'b0; term_valid = 1'b1; term_data = 16'd55;
        @(posedge clock); #1;
        checks++; if (term_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", term_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        term_valid = 1'b0;
    endtask

    task automatic test_basic();
        int dc, nd; logic [17:0] g; bit bok, se;
        run_eval(100, -30, 7, 1, 0, -1, 3, dc, g, nd, bok, se);
        checks++; if (dc !== 13) begin errors++; $display("FAIL basic_latency got %0d want 13", dc); end
        checks++; if (g !== 18'd78) begin errors++; $display("FAIL basic_sum got %0d want 78", g); end
        checks++; if (!bok) begin errors++; $display("FAIL basic_busy got 0 want 1"); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", nd); end
    endtask

    task automatic test_max_magnitude();
        int dc, nd; logic [17:0] g; bit bok, se;
        run_eval(32767, 32767, 32767, 32767, 0, -1, 1, dc, g, nd, bok, se);
        checks++; if (g !== 18'd131068) begin errors++; $display("FAIL max_pos_sum got %0d want 131068", g); end
        run_eval(-32768, -32768, -32768, -32768, 0, -1, 1, dc, g, nd, bok, se);
        checks++; if (g !== 18'h20000) begin errors++; $display("FAIL max_neg_sum got %0h want 20000", g); end
        checks++; if (dc !== 13) begin errors++; $display("FAIL max_latency got %0d want 13", dc); end
    endtask

    task automatic test_stall();
        int dc, nd; logic [17:0] g; bit bok, se;
        run_eval(100, -30, 7, 1, 5, -1, 1, dc, g, nd, bok, se);
        checks++; if (dc !== 18) begin errors++; $display("FAIL stall_latency got %0d want 18", dc); end
        checks++; if (g !== 18'd78) begin errors++; $display("FAIL stall_sum got %0d want 78", g); end
    endtask

    task automatic test_start_busy();
        int dc, nd; logic [17:0] g; bit bok, se;
        run_eval(10, 20, 30, 40, 0, 4, 25, dc, g, nd, bok, se);
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", nd); end
        checks++; if (g !== 18'd100) begin errors++; $display("FAIL busy_start_sum got %0d want 100", g); end
        checks++; if (dc !== 13) begin errors++; $display("FAIL busy_start_latency got %0d want 13", dc); end
    endtask

    task automatic test_reset_mid();
        int hs_cnt = 0, t = 0, dones = 0, dc, nd; logic [17:0] g; bit bok, se, hs;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; term_valid = 1'b1; term_data = 16'd500;
        while (hs_cnt < 2 && t < 20) begin
            @(negedge clock); hs = term_valid && term_ready;
            @(posedge clock); #1;
            t++; if (hs) hs_cnt++;
        end
        checks++; if (hs_cnt !== 2) begin errors++; $display("FAIL reset_mid_handshakes got %0d want 2", hs_cnt); end
        term_valid = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", busy); end
        checks++; if (sum !== 18'd0) begin errors++; $display("FAIL reset_mid_sum got %0d want 0", sum); end
        checks++; if (term_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready got %b want 0", term_ready); end
        repeat (12) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d want 0", dones); end
        run_eval(5, 6, 7, 8, 0, -1, 1, dc, g, nd, bok, se);
        checks++; if (g !== 18'd26) begin errors++; $display("FAIL reset_mid_restart_sum got %0d want 26", g); end
    endtask

    task automatic test_back_to_back();
        int dc, nd; logic [17:0] g; bit bok, se;
        run_eval(-7, 8, 9, -20, 0, -1, 1, dc, g, nd, bok, se);
        checks++; if (g !== 18'h3FFF6) begin errors++; $display("FAIL b2b_first_sum got %0h want 3fff6", g); end
        run_eval(1, 2, 3, 4, 0, -1, 1, dc, g, nd, bok, se);
        checks++; if (g !== 18'd10) begin errors++; $display("FAIL b2b_second_sum got %0d want 10", g); end
        checks++; if (se) begin errors++; $display("FAIL b2b_sum_held got changed want held"); end
        checks++; if (dc !== 13) begin errors++; $display("FAIL b2b_latency got %0d want 13", dc); end
    endtask

    task automatic test_degree0();
        int t = 0, dc = -1;
        logic [16:0] g = '0;
        z_start = 1'b1;
        @(posedge clock); #1;
        z_start = 1'b0; z_valid = 1'b1; z_data = 16'hFFFB;
        while (dc < 0 && t < 20) begin
            @(posedge clock); #1;
            t++;
            if (z_done) begin dc = t; g = z_sum; end
        end
        z_valid = 1'b0;
        checks++; if (dc !== 4) begin errors++; $display("FAIL deg0_latency got %0d want 4", dc); end
        checks++; if (g !== 17'h1FFFB) begin errors++; $display("FAIL deg0_sum got %0h want 1fffb", g); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_magnitude();
        test_stall();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_degree0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
